// File: rtl/writeback_stage_pkg.sv
// Shared pipeline encodings for the writeback stage: result source and load size.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_NONE = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } load_size_e;

    localparam int XLEN = 32;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load alignment: picks the addressed byte/half-word and extends it to 32 bits.
module load_extend
    import writeback_stage_pkg::*;
(
    input  logic [XLEN-1:0] load_data,
    input  logic [1:0]      byte_offset,
    input  logic [1:0]      load_size,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] value
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    function automatic logic [XLEN-1:0] extend_byte(input logic signed [7:0] b, input logic zext);
        return zext ? {24'd0, b} : XLEN'(b);
    endfunction

    function automatic logic [XLEN-1:0] extend_half(input logic signed [15:0] h, input logic zext);
        return zext ? {16'd0, h} : XLEN'(h);
    endfunction

    always_comb begin
        byte_sel = load_data[{byte_offset, 3'b000} +: 8];
        half_sel = byte_offset[1] ? load_data[31:16] : load_data[15:0];
        value    = load_data;
        // Size code 3 is unused by the decoder and falls through to WORD.
        case (load_size)
            LS_BYTE: value = extend_byte(byte_sel, load_unsigned);
            LS_HALF: value = extend_half(half_sel, load_unsigned);
            default: value = load_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers the selected result into the register-file write port and counts retirements.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic                     hold,
    input  logic [4:0]               mem_rd,
    input  logic [1:0]               mem_wb_sel,
    input  logic [XLEN-1:0]          mem_alu_result,
    input  logic [XLEN-1:0]          mem_load_data,
    input  logic [1:0]               mem_byte_offset,
    input  logic [1:0]               mem_load_size,
    input  logic                     mem_load_unsigned,
    input  logic [XLEN-1:0]          mem_pc_plus4,
    output logic [4:0]               write_address,
    output logic [XLEN-1:0]          write_data,
    output logic                     write_enable,
    output logic                     retire,
    output logic [INSTRET_WIDTH-1:0] instret
);

    logic            transfer_p0;
    logic            write_p0;
    logic [XLEN-1:0] load_value_p0;
    logic [XLEN-1:0] result_p0;

    assign mem_ready   = !hold;
    assign transfer_p0 = mem_valid && mem_ready;
    assign write_p0    = (mem_wb_sel != WB_NONE) && (mem_rd != 5'd0);

    load_extend u_load_extend (
        .load_data     (mem_load_data),
        .byte_offset   (mem_byte_offset),
        .load_size     (mem_load_size),
        .load_unsigned (mem_load_unsigned),
        .value         (load_value_p0)
    );

    always_comb begin
        result_p0 = mem_alu_result;
        case (mem_wb_sel)
            WB_LOAD: result_p0 = load_value_p0;
            WB_PC4:  result_p0 = mem_pc_plus4;
            default: result_p0 = mem_alu_result;
        endcase
    end

    // p0 -> p1: register-file write port and retirement bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_address <= '0;
            write_data    <= '0;
            write_enable  <= 1'b0;
            retire        <= 1'b0;
            instret       <= '0;
        end else begin
            write_enable <= 1'b0;
            retire       <= 1'b0;
            if (transfer_p0) begin
                write_address <= mem_rd;
                write_data    <= result_p0;
                write_enable  <= write_p0;
                retire        <= 1'b1;
                instret       <= instret + INSTRET_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a scoreboard of expected register-file writes.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic        hold;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [1:0]  mem_byte_offset;
    logic [1:0]  mem_load_size;
    logic        mem_load_unsigned;
    logic [31:0] mem_pc_plus4;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        retire;
    logic [63:0] instret;

    writeback_stage #(.INSTRET_WIDTH(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .hold              (hold),
        .mem_rd            (mem_rd),
        .mem_wb_sel        (mem_wb_sel),
        .mem_alu_result    (mem_alu_result),
        .mem_load_data     (mem_load_data),
        .mem_byte_offset   (mem_byte_offset),
        .mem_load_size     (mem_load_size),
        .mem_load_unsigned (mem_load_unsigned),
        .mem_pc_plus4      (mem_pc_plus4),
        .write_address     (write_address),
        .write_data        (write_data),
        .write_enable      (write_enable),
        .retire            (retire),
        .instret           (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_instret;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the cycle's outputs with the scoreboard head when the stage retires.
    task automatic observe(input string tag);
        exp_t e;
        if (retire === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_unexpected_retire"}, 64'(retire), 64'd0);
            end else begin
                e = sb.pop_front();
                exp_instret = exp_instret + 64'd1;
                chk({tag, "_we"}, 64'(write_enable), 64'(e.we));
                chk({tag, "_addr"}, 64'(write_address), 64'(e.addr));
                chk({tag, "_data"}, 64'(write_data), 64'(e.data));
                last_addr = e.addr;
                last_data = e.data;
            end
        end else begin
            chk({tag, "_idle_we"}, 64'(write_enable), 64'd0);
            chk({tag, "_hold_addr"}, 64'(write_address), 64'(last_addr));
            chk({tag, "_hold_data"}, 64'(write_data), 64'(last_data));
        end
        chk({tag, "_instret"}, instret, exp_instret);
    endtask

    task automatic drive(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [1:0] off, input logic [1:0] size,
                         input logic uns, input logic [31:0] pc4);
        @(negedge clk);
        mem_valid         = 1'b1;
        mem_rd            = rd;
        mem_wb_sel        = sel;
        mem_alu_result    = alu;
        mem_load_data     = ld;
        mem_byte_offset   = off;
        mem_load_size     = size;
        mem_load_unsigned = uns;
        mem_pc_plus4      = pc4;
    endtask

    task automatic xfer(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [1:0] off,
                        input logic [1:0] size, input logic uns, input logic [31:0] pc4,
                        input logic exp_we, input logic [31:0] exp_data);
        exp_t e;
        drive(rd, sel, alu, ld, off, size, uns, pc4);
        e.we = exp_we;
        e.addr = rd;
        e.data = exp_data;
        sb.push_back(e);
        tick();
        chk({tag, "_retire"}, 64'(retire), 64'd1);
        observe(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        mem_valid = 1'b0;
        tick();
        chk({tag, "_retire"}, 64'(retire), 64'd0);
        observe(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; mem_valid = 1'b0; hold = 1'b0;
        mem_rd = '0; mem_wb_sel = 2'd3; mem_alu_result = '0; mem_load_data = '0;
        mem_byte_offset = '0; mem_load_size = '0; mem_load_unsigned = 1'b0; mem_pc_plus4 = '0;
        exp_instret = '0; last_addr = '0; last_data = '0;
        tick(); tick();
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_addr", 64'(write_address), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle("post_rst");

        // ALU write, then an idle cycle that must hold address/data
        xfer("alu", 5'd5, 2'd0, 32'hDEADBEEF, 32'h0, 2'd0, 2'd2, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        chk("alu_instret_is_1", instret, 64'd1);
        idle("alu_idle");

        // Load extension, back-to-back transfers
        xfer("lb_s3", 5'd1, 2'd1, 32'h0, 32'h80FF7F01, 2'd3, 2'd0, 1'b0, 32'h0, 1'b1, 32'hFFFFFF80);
        xfer("lbu_3", 5'd2, 2'd1, 32'h0, 32'h80FF7F01, 2'd3, 2'd0, 1'b1, 32'h0, 1'b1, 32'h00000080);
        xfer("lh_s2", 5'd3, 2'd1, 32'h0, 32'h80FF7F01, 2'd2, 2'd1, 1'b0, 32'h0, 1'b1, 32'hFFFF80FF);
        xfer("lb_s1", 5'd4, 2'd1, 32'h0, 32'h80FF7F01, 2'd1, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0000007F);
        xfer("lb_s2", 5'd6, 2'd1, 32'h0, 32'h80FF7F01, 2'd2, 2'd0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
        xfer("lhu_3", 5'd7, 2'd1, 32'h0, 32'h80FF7F01, 2'd3, 2'd1, 1'b1, 32'h0, 1'b1, 32'h000080FF);
        xfer("lh_s0", 5'd8, 2'd1, 32'h0, 32'h80FF7F01, 2'd0, 2'd1, 1'b0, 32'h0, 1'b1, 32'h00007F01);
        xfer("lw_1u", 5'd9, 2'd1, 32'h0, 32'h80FF7F01, 2'd1, 2'd2, 1'b1, 32'h0, 1'b1, 32'h80FF7F01);
        xfer("lsz3",  5'd10, 2'd1, 32'h0, 32'h80FF7F01, 2'd2, 2'd3, 1'b0, 32'h0, 1'b1, 32'h80FF7F01);
        idle("ld_idle");

        // PC4 with rd=0 and NONE still retire but do not write
        xfer("pc4_r0", 5'd0, 2'd2, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 32'h00000104, 1'b0, 32'h00000104);
        xfer("pc4_r11", 5'd11, 2'd2, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 32'h00000108, 1'b1, 32'h00000108);
        xfer("none", 5'd12, 2'd3, 32'h55AA55AA, 32'h0, 2'd0, 2'd2, 1'b0, 32'h0, 1'b0, 32'h55AA55AA);
        idle("pc_idle");

        // Stall: valid held high with hold for three cycles
        drive(5'd13, 2'd0, 32'h12345678, 32'h0, 2'd0, 2'd2, 1'b0, 32'h0);
        hold = 1'b1;
        #1;
        chk("hold_ready", 64'(mem_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_retire", 64'(retire), 64'd0);
            observe("hold");
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk("release_ready", 64'(mem_ready), 64'd1);
        sb.push_back('{we: 1'b1, addr: 5'd13, data: 32'h12345678});
        tick();
        chk("release_retire", 64'(retire), 64'd1);
        observe("release");
        idle("release_idle");

        // Counter wrap: preload near all-ones, then two back-to-back transfers
        @(negedge clk);
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.instret;
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        xfer("wrap_a", 5'd14, 2'd0, 32'hA, 32'h0, 2'd0, 2'd2, 1'b0, 32'h0, 1'b1, 32'hA);
        chk("wrap_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        xfer("wrap_b", 5'd15, 2'd0, 32'hB, 32'h0, 2'd0, 2'd2, 1'b0, 32'h0, 1'b1, 32'hB);
        chk("wrap_zero", instret, 64'd0);
        idle("wrap_idle");

        // Transfer attempted during reset is discarded; mem_ready still follows hold
        drive(5'd3, 2'd0, 32'hCAFEF00D, 32'h0, 2'd0, 2'd2, 1'b0, 32'h0);
        rst = 1'b0;
        hold = 1'b1;
        #1;
        chk("rst_ready_hold", 64'(mem_ready), 64'd0);
        hold = 1'b0;
        #1;
        chk("rst_ready", 64'(mem_ready), 64'd1);
        tick();
        chk("rstx_we", 64'(write_enable), 64'd0);
        chk("rstx_retire", 64'(retire), 64'd0);
        chk("rstx_instret", instret, 64'd0);
        chk("rstx_addr", 64'(write_address), 64'd0);
        chk("rstx_data", 64'(write_data), 64'd0);
        exp_instret = '0; last_addr = '0; last_data = '0;
        @(negedge clk);
        mem_valid = 1'b0;
        rst = 1'b1;
        idle("after_rstx");
        xfer("final", 5'd31, 2'd0, 32'h0BADF00D, 32'h0, 2'd0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0BADF00D);
        chk("final_instret", instret, 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter INSTRET_WIDTH, default 64, width of the retired-instruction counter.
REQ-002 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-004 SHALL have ports: mem_valid  in  1  upstream memory stage presents a result.
REQ-005 SHALL have ports: mem_ready  out  1  stage accepts the result this cycle.
REQ-006 SHALL have ports: hold  in  1  stall request; deasserts mem_ready.
REQ-007 SHALL have ports: mem_rd  in  5  destination register index.
REQ-008 SHALL have ports: mem_wb_sel  in  2  result source: ALU, LOAD, PC4; code 3 is NONE (no write).
REQ-009 SHALL have ports: mem_alu_result  in  32  ALU or CSR result.
REQ-010 SHALL have ports: mem_load_data  in  32  raw aligned word read from data memory.
REQ-011 SHALL have ports: mem_byte_offset  in  2  load address bits [1:0].
REQ-012 SHALL have ports: mem_load_size  in  2  BYTE, HALF, WORD.
REQ-013 SHALL have ports: mem_load_unsigned  in  1  zero-extend instead of sign-extend.
REQ-014 SHALL have ports: mem_pc_plus4  in  32  link value for JAL/JALR.
REQ-015 SHALL have ports: write_address / write_data / write_enable  out  5 / 32 / 1  register file write port.
REQ-016 SHALL have ports: retire  out  1  one-cycle pulse per retired instruction.
REQ-017 SHALL have ports: instret  out  INSTRET_WIDTH  retired-instruction count.

Function
REQ-018 mem_ready SHALL equal !hold, combinationally; a transfer occurs on a rising edge with mem_valid && mem_ready.
REQ-019 On a transfer, write_address, write_data and write_enable SHALL be registered, giving one-cycle latency: the register file commits on the following edge.
REQ-020 write_enable SHALL be 1 only in the cycle after a transfer with mem_wb_sel != NONE and mem_rd != 0; otherwise it SHALL be 0.
REQ-021 Cycles without a transfer SHALL drive write_enable 0; write_address and write_data SHALL hold their previous values.
REQ-022 write_data SHALL be mem_alu_result for ALU, mem_pc_plus4 for PC4, and the extended load value for LOAD.
REQ-023 BYTE: select mem_load_data[8*off+7 : 8*off], with off = mem_byte_offset; sign- or zero-extend to 32 bits.
REQ-024 HALF: select the half-word indexed by mem_byte_offset[1]; ignore mem_byte_offset[0]; sign- or zero-extend.
REQ-025 WORD: pass mem_load_data unchanged; ignore mem_byte_offset and mem_load_unsigned.
REQ-026 mem_load_size code 3 SHALL be treated as WORD.
REQ-027 retire SHALL pulse high in the cycle after every transfer, including NONE and rd=0 transfers.
REQ-028 instret SHALL increment by 1 on each transfer and wrap modulo 2^INSTRET_WIDTH to 0 without error.
REQ-029 hold asserted while mem_valid is high SHALL block the transfer; inputs are re-sampled when hold drops.

Reset
REQ-030 While rst==0 at a rising edge, the block SHALL clear write_enable, retire, write_address, write_data and instret to 0.
REQ-031 A transfer coinciding with an active reset SHALL be discarded; it causes no write and no count.
REQ-032 mem_ready SHALL still follow !hold during reset.

Structure
REQ-033 The wb_sel encoding (ALU=0, LOAD=1, PC4=2, NONE=3) and load_size encoding (BYTE=0, HALF=1, WORD=2) SHALL be typedef enums in the shared pipeline package.
REQ-034 Load alignment and extension SHALL be a combinational sub-module, load_extend.

Verification
REQ-035 ALU, rd=5, result 0xDEADBEEF, transfer at edge N -> write_enable=1, addr=5, data=0xDEADBEEF in cycle N+1; retire=1; instret=1.
REQ-036 LOAD BYTE signed, word 0x80FF7F01, off=3 -> 0xFFFFFF80; same unsigned -> 0x00000080; HALF signed, off=2 -> 0xFFFF80FF.
REQ-037 PC4, rd=0, pc_plus4 0x00000104 -> write_enable=0; retire=1; instret increments.
REQ-038 hold=1 for 3 cycles with mem_valid=1 -> mem_ready=0, no write or retire; on release, exactly one write occurs.
REQ-039 Preload instret to 2^64-1 through back-to-back transfers (force the counter) -> next transfer gives instret=0.
REQ-040 rst=0 at an edge with mem_valid=1 -> next cycle shows write_enable=0, retire=0, instret=0.
